// File: rtl/z80_reti_ctl.sv
// Z80 bus watcher: interrupt-acknowledge qualifier, RETI/RETN strobes,
// last acknowledge vector and outstanding-interrupt depth tracking.
module z80_reti_ctl #(
    parameter int DEPTH_W = 3
) (
    input  logic               I_CLK,
    input  logic               I_RESET_n,
    input  logic               I_CLKEN,
    input  logic               I_M1_n,
    input  logic               I_MREQ_n,
    input  logic               I_IORQ_n,
    input  logic               I_RD_n,
    input  logic [7:0]         I_D,
    output logic               O_SPM1,
    output logic               O_RETI,
    output logic               O_RETN,
    output logic [7:0]         O_VEC,
    output logic [DEPTH_W-1:0] O_DEPTH,
    output logic               O_ERR
);

    typedef enum logic {
        S_NORM,
        S_ED
    } state_t;

    localparam logic [DEPTH_W-1:0] DMAX = '1;
    localparam logic [DEPTH_W-1:0] DONE = 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_m1;
    logic               r_valid;
    logic               r_is_ack;
    logic [7:0]         r_op;
    logic               r_reti;
    logic               r_retn;
    logic [7:0]         r_vec;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_err;
    logic               w_end;
    logic               w_ack_end;
    logic               w_fetch_end;
    logic               w_reti_ev;
    logic               w_retn_ev;

    assign O_SPM1  = ~I_M1_n & ~I_IORQ_n;
    assign O_RETI  = r_reti;
    assign O_RETN  = r_retn;
    assign O_VEC   = r_vec;
    assign O_DEPTH = r_depth;
    assign O_ERR   = r_err;

    // r_valid masks the bogus "end" implied by r_m1 resetting to 0
    assign w_end       = I_CLKEN & r_valid & ~r_m1 & I_M1_n;
    assign w_ack_end   = w_end & r_is_ack;
    assign w_fetch_end = w_end & ~r_is_ack;

    always_ff @(posedge I_CLK or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            r_m1     <= 1'b0;
            r_valid  <= 1'b0;
            r_is_ack <= 1'b0;
            r_op     <= 8'h00;
        end else if (I_CLKEN) begin
            r_m1 <= I_M1_n;
            if (!I_M1_n) begin
                r_valid <= 1'b1;
                if (!I_IORQ_n) begin
                    r_is_ack <= 1'b1;
                    r_op     <= I_D;
                end else if (!I_MREQ_n && !I_RD_n && !r_is_ack) begin
                    r_op <= I_D;
                end
            end else begin
                r_valid  <= 1'b0;
                r_is_ack <= 1'b0;
            end
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            r_state <= S_NORM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_reti_ev   = 1'b0;
        w_retn_ev   = 1'b0;
        if (w_fetch_end) begin
            unique case (r_state)
                S_NORM: begin
                    if (r_op == 8'hED) begin
                        w_state_nxt = S_ED;
                    end
                end
                S_ED: begin
                    if (r_op == 8'h4D) begin
                        w_reti_ev   = 1'b1;
                        w_state_nxt = S_NORM;
                    end else if (r_op == 8'h45) begin
                        w_retn_ev   = 1'b1;
                        w_state_nxt = S_NORM;
                    end else if (r_op != 8'hED) begin
                        w_state_nxt = S_NORM;
                    end
                end
                default: w_state_nxt = S_NORM;
            endcase
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            r_reti  <= 1'b0;
            r_retn  <= 1'b0;
            r_vec   <= 8'h00;
            r_depth <= '0;
            r_err   <= 1'b0;
        end else if (I_CLKEN) begin
            r_reti <= w_reti_ev;
            r_retn <= w_retn_ev;
            if (w_ack_end) begin
                r_vec <= r_op;
                if (r_depth == DMAX) begin
                    r_err <= 1'b1;
                end else begin
                    r_depth <= r_depth + DONE;
                end
            end else if (w_reti_ev) begin
                if (r_depth == '0) begin
                    r_err <= 1'b1;
                end else begin
                    r_depth <= r_depth - DONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_z80_reti_ctl.sv
// Directed bench for z80_reti_ctl: expected strobes queued at stimulus
// time and retired by a pulse monitor on each enabled clock.
module tb_z80_reti_ctl;

    logic       clk;
    logic       rst_n;
    logic       clken;
    logic       m1_n;
    logic       mreq_n;
    logic       iorq_n;
    logic       rd_n;
    logic [7:0] d;
    logic       spm1;
    logic       reti;
    logic       retn;
    logic [7:0] vec;
    logic [2:0] depth;
    logic       err;

    int checks = 0;
    int errors = 0;
    int n_reti = 0;
    int n_retn = 0;
    int exp_q[$];

    z80_reti_ctl #(.DEPTH_W(3)) dut (
        .I_CLK    (clk),
        .I_RESET_n(rst_n),
        .I_CLKEN  (clken),
        .I_M1_n   (m1_n),
        .I_MREQ_n (mreq_n),
        .I_IORQ_n (iorq_n),
        .I_RD_n   (rd_n),
        .I_D      (d),
        .O_SPM1   (spm1),
        .O_RETI   (reti),
        .O_RETN   (retn),
        .O_VEC    (vec),
        .O_DEPTH  (depth),
        .O_ERR    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor: each strobe seen on an enabled clock retires one
    // queued expectation (1 = RETI, 2 = RETN).
    always @(posedge clk) begin
        logic ce;
        int   kind;
        int   want;
        ce = clken;
        #1;
        if (ce && (reti || retn)) begin
            if (reti) n_reti++;
            if (retn) n_retn++;
            chk("no_overlap", {31'd0, reti & retn}, 32'd0);
            kind = reti ? 1 : 2;
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
            chk("pulse_kind", kind, want);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m1_n   = 1'b1;
        mreq_n = 1'b1;
        iorq_n = 1'b1;
        rd_n   = 1'b1;
    endtask

    task automatic fetch(input logic [7:0] op);
        m1_n   = 1'b0;
        mreq_n = 1'b0;
        rd_n   = 1'b0;
        d      = op;
        tick(2);
        idle();
        tick(1);
    endtask

    task automatic ack(input logic [7:0] v);
        m1_n   = 1'b0;
        iorq_n = 1'b0;
        d      = v;
        tick(3);
        idle();
        tick(1);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        rst_n = 1'b0;
        clken = 1'b1;
        d     = 8'h00;
        idle();
        tick(3);
        rst_n = 1'b1;
        tick(10);
        chk("rst_vec", vec, 32'h00);
        chk("rst_depth", depth, 32'd0);
        chk("rst_reti", reti, 32'd0);
        chk("rst_retn", retn, 32'd0);
        chk("rst_err", err, 32'd0);
        chk("rst_spm1", spm1, 32'd0);

        m1_n   = 1'b0;
        iorq_n = 1'b0;
        d      = 8'hA6;
        #1;
        chk("spm1_comb", spm1, 32'd1);
        tick(3);
        idle();
        #1;
        chk("spm1_low", spm1, 32'd0);
        tick(1);
        chk("ack_vec", vec, 32'hA6);
        chk("ack_depth", depth, 32'd1);

        exp_q.push_back(1);
        fetch(8'hED);
        fetch(8'h4D);
        chk("reti_hi", reti, 32'd1);
        tick(1);
        chk("reti_lo", reti, 32'd0);
        chk("reti_depth", depth, 32'd0);
        chk("reti_err", err, 32'd0);
        chk("reti_cnt1", n_reti, 32'd1);

        exp_q.push_back(2);
        fetch(8'hED);
        fetch(8'h45);
        chk("retn_hi", retn, 32'd1);
        tick(1);
        chk("retn_cnt", n_retn, 32'd1);
        chk("retn_depth", depth, 32'd0);

        ack(8'h11);
        fetch(8'hED);
        fetch(8'h00);
        fetch(8'h4D);
        tick(1);
        chk("ed00_none", n_reti, 32'd1);
        exp_q.push_back(1);
        fetch(8'hED);
        fetch(8'hED);
        fetch(8'h4D);
        tick(1);
        chk("eded_one", n_reti, 32'd2);
        fetch(8'hDD);
        fetch(8'h4D);
        tick(1);
        chk("dd_none", n_reti, 32'd2);
        chk("seq_depth", depth, 32'd0);

        exp_q.push_back(1);
        fetch(8'hED);
        ack(8'h22);
        chk("mid_depth", depth, 32'd1);
        fetch(8'h4D);
        tick(1);
        chk("ack_split", n_reti, 32'd3);
        chk("split_vec", vec, 32'h22);
        chk("split_depth", depth, 32'd0);
        chk("split_err", err, 32'd0);

        for (int i = 0; i < 8; i++) ack(8'h30 + 8'(i));
        chk("sat_depth", depth, 32'd7);
        chk("sat_err", err, 32'd1);
        chk("sat_vec", vec, 32'h37);

        do_reset();
        chk("rst2_err", err, 32'd0);
        chk("rst2_depth", depth, 32'd0);
        exp_q.push_back(1);
        fetch(8'hED);
        fetch(8'h4D);
        tick(1);
        chk("under_cnt", n_reti, 32'd4);
        chk("under_depth", depth, 32'd0);
        chk("under_err", err, 32'd1);

        do_reset();
        m1_n   = 1'b0;
        mreq_n = 1'b0;
        rd_n   = 1'b0;
        d      = 8'hED;
        tick(1);
        #2 rst_n = 1'b0;
        idle();
        #2 rst_n = 1'b1;
        tick(2);
        fetch(8'h4D);
        tick(1);
        chk("abort_none", n_reti, 32'd4);
        chk("abort_err", err, 32'd0);

        ack(8'h55);
        exp_q.push_back(1);
        fetch(8'hED);
        fetch(8'h4D);
        clken = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("stretch_hi", reti, 32'd1);
        end
        clken = 1'b1;
        tick(1);
        chk("stretch_lo", reti, 32'd0);
        chk("stretch_cnt", n_reti, 32'd5);
        chk("stretch_depth", depth, 32'd0);
        tick(2);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
